ram_port_arbiter: RTL and testbench

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_ram_port_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Two-master arbiter onto a single RAM port B: round-robin by default, with an
// optional bounded lock that lets one master keep the port for a burst.
module ram_port_arbiter #(
  parameter int MAX_LOCK = 16
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        m0_req_i,
  input  logic        m0_lock_i,
  input  logic [31:0] m0_addr_i,
  input  logic [3:0]  m0_we_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_req_i,
  input  logic        m1_lock_i,
  input  logic [31:0] m1_addr_i,
  input  logic [3:0]  m1_we_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic [31:0] addrb_o,
  output logic        enb_o,
  output logic [3:0]  web_o,
  output logic [31:0] dinb_o,
  input  logic [31:0] doutb_i
);

  localparam logic [1:0] ST_RR    = 2'd0;
  localparam logic [1:0] ST_LOCK0 = 2'd1;
  localparam logic [1:0] ST_LOCK1 = 2'd2;
  localparam logic [7:0] MAX_LOCK_C = 8'(MAX_LOCK);

  logic [1:0]  state_q, state_d;
  logic        prio_q, prio_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        rvalid0_q, rvalid0_d;
  logic        rvalid1_q, rvalid1_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic        gnt0, gnt1;

  // A saturated lock yields to a waiting peer; dropping the lock hands priority over.
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    state_d = state_q;
    prio_d  = prio_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_LOCK0: begin
        if (cnt_q == MAX_LOCK_C && m1_req_i) begin
          gnt1    = 1'b1;
          state_d = ST_RR;
          prio_d  = 1'b0;
          cnt_d   = 8'd0;
        end else begin
          gnt0 = m0_req_i;
          if (!m0_lock_i) begin
            state_d = ST_RR;
            prio_d  = 1'b1;
            cnt_d   = 8'd0;
          end else if (cnt_q != MAX_LOCK_C) begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      ST_LOCK1: begin
        if (cnt_q == MAX_LOCK_C && m0_req_i) begin
          gnt0    = 1'b1;
          state_d = ST_RR;
          prio_d  = 1'b1;
          cnt_d   = 8'd0;
        end else begin
          gnt1 = m1_req_i;
          if (!m1_lock_i) begin
            state_d = ST_RR;
            prio_d  = 1'b0;
            cnt_d   = 8'd0;
          end else if (cnt_q != MAX_LOCK_C) begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: begin
        cnt_d = 8'd0;
        if (m0_req_i && (!m1_req_i || !prio_q)) begin
          gnt0   = 1'b1;
          prio_d = 1'b1;
          if (m0_lock_i) state_d = ST_LOCK0;
        end else if (m1_req_i) begin
          gnt1   = 1'b1;
          prio_d = 1'b0;
          if (m1_lock_i) state_d = ST_LOCK1;
        end
      end
    endcase
    // An access in a reset cycle must not reach the RAM or produce a response.
    if (rst_i) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  always_comb begin
    rvalid0_d = gnt0;
    rvalid1_d = gnt1;
    rdata0_d  = gnt0 ? doutb_i : rdata0_q;
    rdata1_d  = gnt1 ? doutb_i : rdata1_q;
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q   <= ST_RR;
      prio_q    <= 1'b0;
      cnt_q     <= 8'd0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= 32'd0;
      rdata1_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      cnt_q     <= cnt_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign m0_gnt_o    = gnt0;
  assign m1_gnt_o    = gnt1;
  assign enb_o       = gnt0 | gnt1;
  assign addrb_o     = gnt0 ? m0_addr_i  : (gnt1 ? m1_addr_i  : 32'd0);
  assign web_o       = gnt0 ? m0_we_i    : (gnt1 ? m1_we_i    : 4'd0);
  assign dinb_o      = gnt0 ? m0_wdata_i : (gnt1 ? m1_wdata_i : 32'd0);
  assign m0_rvalid_o = rvalid0_q;
  assign m1_rvalid_o = rvalid1_q;
  assign m0_rdata_o  = rdata0_q;
  assign m1_rdata_o  = rdata1_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: a behavioural RAM on port B plus a
// response scoreboard fed from the bench's own reference memory.
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        m0_req_i, m0_lock_i, m1_req_i, m1_lock_i;
  logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
  logic [3:0]  m0_we_i, m1_we_i;
  logic        m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic [31:0] addrb_o, dinb_o, doutb_i;
  logic        enb_o;
  logic [3:0]  web_o;

  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];

  typedef struct {
    bit          port;
    logic [31:0] data;
  } rsp_t;
  rsp_t sbq[$];

  int          checks = 0;
  int          errors = 0;
  int          step_num = 0;
  logic [31:0] exp_rdata0 = 32'd0;
  logic [31:0] exp_rdata1 = 32'd0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.MAX_LOCK(4)) dut (
    .clk(clk), .rst_i(rst_i),
    .m0_req_i(m0_req_i), .m0_lock_i(m0_lock_i), .m0_addr_i(m0_addr_i),
    .m0_we_i(m0_we_i), .m0_wdata_i(m0_wdata_i), .m0_gnt_o(m0_gnt_o),
    .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_lock_i(m1_lock_i), .m1_addr_i(m1_addr_i),
    .m1_we_i(m1_we_i), .m1_wdata_i(m1_wdata_i), .m1_gnt_o(m1_gnt_o),
    .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
    .addrb_o(addrb_o), .enb_o(enb_o), .web_o(web_o), .dinb_o(dinb_o),
    .doutb_i(doutb_i)
  );

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  we);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  assign doutb_i = mem[addrb_o[9:2]];

  always @(posedge clk)
    if (enb_o) mem[addrb_o[9:2]] <= merge_bytes(mem[addrb_o[9:2]], dinb_o, web_o);

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s step %0d observed=%h expected=%h", tag, step_num, obs, exp);
    end
  endtask

  task automatic applyStimulus(
    input logic rst,
    input logic r0, input logic l0, input logic [31:0] a0, input logic [3:0] we0, input logic [31:0] wd0,
    input logic r1, input logic l1, input logic [31:0] a1, input logic [3:0] we1, input logic [31:0] wd1,
    input logic eg0, input logic eg1);
    rsp_t e;
    logic exp_v0, exp_v1;
    @(negedge clk);
    step_num++;
    rst_i = rst;
    m0_req_i = r0; m0_lock_i = l0; m0_addr_i = a0; m0_we_i = we0; m0_wdata_i = wd0;
    m1_req_i = r1; m1_lock_i = l1; m1_addr_i = a1; m1_we_i = we1; m1_wdata_i = wd1;
    #1;
    checkOutput("gnt0", 32'(m0_gnt_o), 32'(eg0));
    checkOutput("gnt1", 32'(m1_gnt_o), 32'(eg1));
    checkOutput("enb", 32'(enb_o), 32'(eg0 | eg1));
    checkOutput("addrb", addrb_o, eg0 ? a0 : (eg1 ? a1 : 32'd0));
    checkOutput("web", 32'(web_o), eg0 ? 32'(we0) : (eg1 ? 32'(we1) : 32'd0));
    checkOutput("dinb", dinb_o, eg0 ? wd0 : (eg1 ? wd1 : 32'd0));
    if (eg0) begin
      sbq.push_back('{port: 1'b0, data: ref_mem[a0[9:2]]});
      ref_mem[a0[9:2]] = merge_bytes(ref_mem[a0[9:2]], wd0, we0);
    end
    if (eg1) begin
      sbq.push_back('{port: 1'b1, data: ref_mem[a1[9:2]]});
      ref_mem[a1[9:2]] = merge_bytes(ref_mem[a1[9:2]], wd1, we1);
    end
    @(posedge clk);
    #1;
    exp_v0 = 1'b0;
    exp_v1 = 1'b0;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (e.port == 1'b0) begin exp_v0 = 1'b1; exp_rdata0 = e.data; end
      else begin exp_v1 = 1'b1; exp_rdata1 = e.data; end
    end
    if (rst) begin
      exp_rdata0 = 32'd0;
      exp_rdata1 = 32'd0;
    end
    checkOutput("rvalid0", 32'(m0_rvalid_o), 32'(exp_v0));
    checkOutput("rvalid1", 32'(m1_rvalid_o), 32'(exp_v1));
    checkOutput("rdata0", m0_rdata_o, exp_rdata0);
    checkOutput("rdata1", m1_rdata_o, exp_rdata1);
  endtask

  // Read-only step with per-step distinct addresses and write data on both masters.
  task automatic basicStimulus(input logic rst, input logic r0, input logic l0,
                               input logic r1, input logic l1,
                               input logic eg0, input logic eg1);
    logic [7:0] s;
    s = step_num[7:0] + 8'd1;
    applyStimulus(rst,
                  r0, l0, {22'h280000, s, 2'b00}, 4'h0, {16'h0D0D, 8'h00, s},
                  r1, l1, {22'h2C0000, s ^ 8'h80, 2'b00}, 4'h0, {16'h1D1D, 8'h00, s},
                  eg0, eg1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'hC0DE0000 | 32'(i);
      ref_mem[i] = 32'hC0DE0000 | 32'(i);
    end
    rst_i = 1'b1;
    m0_req_i = 1'b0; m0_lock_i = 1'b0; m0_addr_i = 32'd0; m0_we_i = 4'd0; m0_wdata_i = 32'd0;
    m1_req_i = 1'b0; m1_lock_i = 1'b0; m1_addr_i = 32'd0; m1_we_i = 4'd0; m1_wdata_i = 32'd0;

    // Reset holds grants off even with both masters requesting.
    basicStimulus(1, 1, 0, 1, 0, 0, 0);
    basicStimulus(1, 0, 0, 0, 0, 0, 0);
    basicStimulus(0, 0, 0, 0, 0, 0, 0);

    // Round-robin alternation, then single requesters.
    basicStimulus(0, 1, 0, 1, 0, 1, 0);
    basicStimulus(0, 1, 0, 1, 0, 0, 1);
    basicStimulus(0, 1, 0, 1, 0, 1, 0);
    basicStimulus(0, 1, 0, 1, 0, 0, 1);
    basicStimulus(0, 0, 0, 1, 0, 0, 1);
    basicStimulus(0, 1, 0, 0, 0, 1, 0);

    // Write then read-back across masters, including a partial-byte write.
    applyStimulus(0, 0, 0, 32'h0, 4'h0, 32'h0, 1, 0, 32'h40, 4'hF, 32'hDEADBEEF, 0, 1);
    applyStimulus(0, 1, 0, 32'h40, 4'h0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 1, 0);
    checkOutput("wr_rd_m0", m0_rdata_o, 32'hDEADBEEF);
    applyStimulus(0, 1, 0, 32'h40, 4'h3, 32'h12345678, 0, 0, 32'h0, 4'h0, 32'h0, 1, 0);
    checkOutput("pre_write_m0", m0_rdata_o, 32'hDEADBEEF);
    applyStimulus(0, 0, 0, 32'h0, 4'h0, 32'h0, 1, 0, 32'h40, 4'h0, 32'h0, 0, 1);
    checkOutput("byte_merge_m1", m1_rdata_o, 32'hDEAD5678);

    // m0 lock for five grants, release hands the port to m1.
    basicStimulus(0, 1, 1, 1, 0, 1, 0);
    basicStimulus(0, 1, 1, 1, 0, 1, 0);
    basicStimulus(0, 1, 1, 1, 0, 1, 0);
    basicStimulus(0, 1, 1, 1, 0, 1, 0);
    basicStimulus(0, 1, 0, 1, 0, 1, 0);
    basicStimulus(0, 1, 0, 1, 0, 0, 1);

    // Reset pulse while m1 holds the lock.
    basicStimulus(0, 0, 0, 1, 1, 0, 1);
    basicStimulus(0, 1, 0, 1, 1, 0, 1);
    basicStimulus(1, 1, 0, 1, 1, 0, 0);
    basicStimulus(0, 1, 0, 1, 0, 1, 0);
    basicStimulus(0, 1, 0, 1, 0, 0, 1);

    // MAX_LOCK=4: m0 keeps the port 5 cycles, then a forced handover.
    basicStimulus(0, 1, 1, 1, 0, 1, 0);
    basicStimulus(0, 1, 1, 1, 0, 1, 0);
    basicStimulus(0, 1, 1, 1, 0, 1, 0);
    basicStimulus(0, 1, 1, 1, 0, 1, 0);
    basicStimulus(0, 1, 1, 1, 0, 1, 0);
    basicStimulus(0, 1, 1, 1, 0, 0, 1);
    basicStimulus(0, 1, 0, 1, 0, 1, 0);
    basicStimulus(0, 1, 0, 1, 0, 0, 1);
    basicStimulus(0, 1, 0, 1, 0, 1, 0);

    // Lock released without a grant still flips priority to the other master.
    basicStimulus(0, 1, 1, 0, 0, 1, 0);
    basicStimulus(0, 0, 0, 1, 0, 0, 0);
    basicStimulus(0, 1, 0, 1, 0, 0, 1);

    // Counter saturates while uncontended, then yields at once to m1.
    basicStimulus(0, 1, 1, 0, 0, 1, 0);
    basicStimulus(0, 1, 1, 0, 0, 1, 0);
    basicStimulus(0, 1, 1, 0, 0, 1, 0);
    basicStimulus(0, 1, 1, 0, 0, 1, 0);
    basicStimulus(0, 1, 1, 0, 0, 1, 0);
    basicStimulus(0, 1, 1, 0, 0, 1, 0);
    basicStimulus(0, 1, 1, 1, 0, 0, 1);
    basicStimulus(0, 0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
